// File: rtl/memarbiter.sv
// Arbiter/sequencer sharing the single-ported unified memory between fetch and the
// memory stage: one fixed-latency access at a time, data preferred, fetch starvation-bounded.
module memarbiter #(
    parameter int WIDTH            = 16,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int LATENCY          = 2,
    parameter int STARVELIMIT      = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fetchReq,
    input  logic [WIDTH-1:0]            fetchAddr,
    output logic                        fetchValid,
    output logic [INSTRUCTIONWIDTH-1:0] fetchData,
    output logic                        fetchStall,
    input  logic                        dataReq,
    input  logic                        dataWrite,
    input  logic [WIDTH-1:0]            dataAddr,
    input  logic [WIDTH-1:0]            dataWdata,
    output logic                        dataValid,
    output logic [WIDTH-1:0]            dataRdata,
    output logic                        dataStall,
    output logic                        memEnable,
    output logic                        memWrite,
    output logic [WIDTH-1:0]            memAddr,
    output logic [WIDTH-1:0]            memWdata,
    input  logic [INSTRUCTIONWIDTH-1:0] memRdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;
    typedef enum logic {FETCH, DATA} ownerT;

    localparam logic [3:0] STREAKMAX = 4'(STARVELIMIT);
    localparam logic [2:0] WAITLOAD  = 3'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 7) begin : gBadLatency
        $error("memarbiter: LATENCY %0d outside 1..7", LATENCY);
    end
    if (STARVELIMIT < 1 || STARVELIMIT > 15) begin : gBadStarve
        $error("memarbiter: STARVELIMIT %0d outside 1..15", STARVELIMIT);
    end

    stateT      state;
    ownerT      owner;
    logic [3:0] streak;
    logic [2:0] waitCnt;
    logic       dataWins;

    assign dataWins   = dataReq && !(fetchReq && streak == STREAKMAX);
    assign fetchStall = fetchReq & ~fetchValid;
    assign dataStall  = dataReq & ~dataValid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= FETCH;
            streak     <= '0;
            waitCnt    <= '0;
            memEnable  <= 1'b0;
            memWrite   <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            fetchValid <= 1'b0;
            dataValid  <= 1'b0;
            fetchData  <= '0;
            dataRdata  <= '0;
        end else begin
            memEnable  <= 1'b0;
            memWrite   <= 1'b0;
            fetchValid <= 1'b0;
            dataValid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fetchReq || dataReq) begin
                        if (dataWins) begin
                            owner    <= DATA;
                            memAddr  <= dataAddr;
                            memWdata <= dataWdata;
                            memWrite <= dataWrite;
                            if (!fetchReq)
                                streak <= '0;
                            else if (streak != STREAKMAX)
                                streak <= streak + 4'd1;
                        end else begin
                            owner   <= FETCH;
                            memAddr <= fetchAddr;
                            streak  <= '0;
                        end
                        memEnable <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // memWrite still holds this access's strobe; only a data owner can set it
                    if (memWrite) begin
                        dataValid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // Reads always pass through WAIT so memRdata is sampled LATENCY
                        // cycles after the strobe, including LATENCY==1 (counter loads 0)
                        waitCnt <= WAITLOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        if (owner == DATA) begin
                            dataRdata <= memRdata[WIDTH-1:0];
                            dataValid <= 1'b1;
                        end else begin
                            fetchData  <= memRdata;
                            fetchValid <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
